// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl: frame-synchronous configuration controller for scaler_h / scaler_v.
//
// Config writes land in a shadow register and are committed to the scaler only at an
// input frame start (vs_i rising), so scale steps never change mid-frame. The block also
// measures input frame geometry from de_i/hs_i/vs_i and flags line-width mismatches.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   cfg_wr, cfg_step_h/v,      one-cycle write strobe and requested step/bypass fields
//   cfg_bypass
//   cfg_busy                   shadow holds uncommitted values
//   de_i, hs_i, vs_i           input video pixel valid / line sync / frame sync
//   scale_step_h/v, bypass     committed configuration to the scaler datapath
//   frame_start_o              one-cycle pulse at each commit point
//   in_w_o, in_h_o             geometry of the last complete frame
//   err_o, err_clr             sticky line-width mismatch flag and its clear
module scaler_cfg_ctrl #(
  parameter int unsigned SCALE_STEP = 128,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [STEP_WIDTH-1:0] cfg_step_h,
  input  logic [STEP_WIDTH-1:0] cfg_step_v,
  input  logic                  cfg_bypass,
  output logic                  cfg_busy,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step_h,
  output logic [STEP_WIDTH-1:0] scale_step_v,
  output logic                  bypass,
  output logic                  frame_start_o,
  output logic [CNT_WIDTH-1:0]  in_w_o,
  output logic [CNT_WIDTH-1:0]  in_h_o,
  output logic                  err_o,
  input  logic                  err_clr
);

  localparam logic [STEP_WIDTH-1:0] StepUnity = STEP_WIDTH'(SCALE_STEP);
  localparam logic [CNT_WIDTH-1:0]  CntMax    = '1;
  localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);

  typedef enum logic {StWaitVs, StActive} state_e;

  state_e                state_q, state_d;
  logic                  vs_q, vs_d, hs_q, hs_d;
  logic [STEP_WIDTH-1:0] sh_h_q, sh_h_d, sh_v_q, sh_v_d;
  logic                  sh_b_q, sh_b_d;
  logic                  busy_q, busy_d;
  logic [STEP_WIDTH-1:0] step_h_q, step_h_d, step_v_q, step_v_d;
  logic                  byp_q, byp_d;
  logic                  fs_q, fs_d;
  logic [CNT_WIDTH-1:0]  pix_q, pix_d, line_q, line_d, ref_w_q, ref_w_d;
  logic [CNT_WIDTH-1:0]  in_w_q, in_w_d, in_h_q, in_h_d;
  logic                  err_q, err_d;

  logic vs_rise, hs_fall, hs_rise, pix_en;

  always_comb begin
    vs_rise = vs_i & ~vs_q;
    hs_fall = hs_q & ~hs_i & vs_i;
    hs_rise = ~hs_q & hs_i & vs_i;
    pix_en  = de_i & ~hs_i & vs_i;

    state_d  = state_q;
    vs_d     = vs_i;
    hs_d     = hs_i;
    sh_h_d   = sh_h_q;
    sh_v_d   = sh_v_q;
    sh_b_d   = sh_b_q;
    busy_d   = busy_q;
    step_h_d = step_h_q;
    step_v_d = step_v_q;
    byp_d    = byp_q;
    fs_d     = vs_rise;
    pix_d    = pix_q;
    line_d   = line_q;
    ref_w_d  = ref_w_q;
    in_w_d   = in_w_q;
    in_h_d   = in_h_q;
    err_d    = err_q;

    // Commit uses the shadow as it stood before this cycle; a coincident write below
    // re-arms busy and waits for the next frame start.
    if (vs_rise && busy_q) begin
      step_h_d = sh_h_q;
      step_v_d = sh_v_q;
      byp_d    = sh_b_q;
      busy_d   = 1'b0;
    end
    if (cfg_wr) begin
      sh_h_d = (cfg_step_h == '0) ? StepUnity : cfg_step_h;
      sh_v_d = (cfg_step_v == '0) ? StepUnity : cfg_step_v;
      sh_b_d = cfg_bypass;
      busy_d = 1'b1;
    end

    unique case (state_q)
      StWaitVs: if (vs_rise) state_d = StActive;
      StActive: begin
        if (!vs_i) begin
          state_d = StWaitVs;
          in_w_d  = ref_w_q;
          in_h_d  = line_q;
        end
      end
      default: state_d = StWaitVs;
    endcase

    // A pixel qualified on the hs_fall cycle is the first pixel of the new line.
    if (hs_fall) begin
      pix_d = pix_en ? CntOne : '0;
    end else if (pix_en && pix_q != CntMax) begin
      pix_d = pix_q + 1'b1;
    end

    if (vs_rise) begin
      line_d = hs_fall ? CntOne : '0;
    end else if (hs_fall && line_q != CntMax) begin
      line_d = line_q + 1'b1;
    end

    // Width check only inside a frame that began after reset; set wins over clear.
    if (err_clr) err_d = 1'b0;
    if (hs_rise && state_q == StActive) begin
      if (line_q == CntOne) begin
        ref_w_d = pix_q;
      end else if (pix_q != ref_w_q) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitVs;
      vs_q     <= 1'b1;
      hs_q     <= 1'b1;
      sh_h_q   <= StepUnity;
      sh_v_q   <= StepUnity;
      sh_b_q   <= 1'b0;
      busy_q   <= 1'b0;
      step_h_q <= StepUnity;
      step_v_q <= StepUnity;
      byp_q    <= 1'b0;
      fs_q     <= 1'b0;
      pix_q    <= '0;
      line_q   <= '0;
      ref_w_q  <= '0;
      in_w_q   <= '0;
      in_h_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      sh_h_q   <= sh_h_d;
      sh_v_q   <= sh_v_d;
      sh_b_q   <= sh_b_d;
      busy_q   <= busy_d;
      step_h_q <= step_h_d;
      step_v_q <= step_v_d;
      byp_q    <= byp_d;
      fs_q     <= fs_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      ref_w_q  <= ref_w_d;
      in_w_q   <= in_w_d;
      in_h_q   <= in_h_d;
      err_q    <= err_d;
    end
  end

  assign cfg_busy      = busy_q;
  assign scale_step_h  = step_h_q;
  assign scale_step_v  = step_v_q;
  assign bypass        = byp_q;
  assign frame_start_o = fs_q;
  assign in_w_o        = in_w_q;
  assign in_h_o        = in_h_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Self-checking bench for scaler_cfg_ctrl: drives whole video frames with optional
// config writes, short lines, error clears and a mid-frame reset, and compares the DUT
// against a frame-level model of committed config, geometry and error state.
module tb_scaler_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr, cfg_bypass, cfg_busy;
  logic [15:0] cfg_step_h, cfg_step_v;
  logic        de_i, hs_i, vs_i;
  logic [15:0] scale_step_h, scale_step_v;
  logic        bypass, frame_start_o, err_o, err_clr;
  logic [15:0] in_w_o, in_h_o;

  scaler_cfg_ctrl #(
    .SCALE_STEP(128),
    .STEP_WIDTH(16),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_step_h   (cfg_step_h),
    .cfg_step_v   (cfg_step_v),
    .cfg_bypass   (cfg_bypass),
    .cfg_busy     (cfg_busy),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .scale_step_h (scale_step_h),
    .scale_step_v (scale_step_v),
    .bypass       (bypass),
    .frame_start_o(frame_start_o),
    .in_w_o       (in_w_o),
    .in_h_o       (in_h_o),
    .err_o        (err_o),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: committed config, pending shadow, frame tracking, geometry, error flag.
  logic [15:0] exp_h, exp_v, m_sh_h, m_sh_v, m_in_w, m_in_h;
  logic        exp_b, m_sh_b, m_busy, m_active, m_err;
  int          m_ref;

  // Frame description for run_frame.
  int          f_w, f_h, f_period, f_short_line, f_short_w, f_clr_line, f_wr_line, f_rst_line;
  bit          f_wr_at_vs;
  logic [15:0] wr_h, wr_v;
  logic        wr_b;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_h = 16'd128; exp_v = 16'd128; exp_b = 1'b0;
    m_busy = 1'b0; m_active = 1'b0; m_err = 1'b0;
    m_in_w = 16'd0; m_in_h = 16'd0; m_ref = 0;
  endtask

  task automatic model_write();
    m_sh_h = (wr_h == 16'd0) ? 16'd128 : wr_h;
    m_sh_v = (wr_v == 16'd0) ? 16'd128 : wr_v;
    m_sh_b = wr_b;
    m_busy = 1'b1;
  endtask

  task automatic drive_wr();
    cfg_wr = 1'b1; cfg_step_h = wr_h; cfg_step_v = wr_v; cfg_bypass = wr_b;
  endtask

  task automatic new_frame(input int w, input int h, input int period);
    f_w = w; f_h = h; f_period = period;
    f_short_line = 0; f_short_w = 0; f_clr_line = 0; f_wr_line = 0; f_rst_line = 0;
    f_wr_at_vs = 1'b0;
  endtask

  task automatic run_frame();
    int npix;
    int gap;
    gap = (f_period > 1) ? f_period - 1 : 0;
    vs_i = 1'b0; hs_i = 1'b1; cfg_wr = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      de_i = 1'($urandom);
      cyc();
    end
    // Frame start
    vs_i = 1'b1; de_i = 1'($urandom);
    if (f_wr_at_vs) drive_wr();
    cyc();
    cfg_wr = 1'b0;
    if (m_busy) begin
      exp_h = m_sh_h; exp_v = m_sh_v; exp_b = m_sh_b; m_busy = 1'b0;
    end
    if (f_wr_at_vs) model_write();
    m_active = 1'b1;
    n_chk++;
    if (frame_start_o !== 1'b1 || scale_step_h !== exp_h || scale_step_v !== exp_v ||
        bypass !== exp_b || cfg_busy !== m_busy) begin
      n_fail++;
      $display("FAIL commit: fs=%0b h=%0d v=%0d byp=%0b busy=%0b, want fs=1 h=%0d v=%0d byp=%0b busy=%0b",
               frame_start_o, scale_step_h, scale_step_v, bypass, cfg_busy,
               exp_h, exp_v, exp_b, m_busy);
    end
    de_i = 1'($urandom);
    cyc();
    n_chk++;
    if (frame_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_pulse_width: frame_start_o=%0b, want 0", frame_start_o);
    end
    for (int ln = 1; ln <= f_h; ln++) begin
      npix = (ln == f_short_line) ? f_short_w : f_w;
      hs_i = 1'b1; de_i = 1'($urandom);
      if (ln == f_wr_line) drive_wr();
      cyc();
      cfg_wr = 1'b0;
      if (ln == f_wr_line) begin
        model_write();
        n_chk++;
        if (cfg_busy !== 1'b1 || scale_step_h !== exp_h || scale_step_v !== exp_v ||
            bypass !== exp_b) begin
          n_fail++;
          $display("FAIL deferred: busy=%0b h=%0d v=%0d byp=%0b, want busy=1 h=%0d v=%0d byp=%0b",
                   cfg_busy, scale_step_h, scale_step_v, bypass, exp_h, exp_v, exp_b);
        end
      end
      hs_i = 1'b0; de_i = 1'b0;
      cyc();
      for (int p = 0; p < npix; p++) begin
        de_i = 1'b1;
        cyc();
        if (ln == f_rst_line && p == npix / 2) begin
          rst = 1'b1;
          #2;
          model_reset();
          n_chk++;
          if (scale_step_h !== 16'd128 || scale_step_v !== 16'd128 || bypass !== 1'b0 ||
              cfg_busy !== 1'b0 || frame_start_o !== 1'b0 || err_o !== 1'b0 ||
              in_w_o !== 16'd0 || in_h_o !== 16'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: h=%0d v=%0d byp=%0b busy=%0b fs=%0b err=%0b w=%0d hgt=%0d, want 128 128 0 0 0 0 0 0",
                     scale_step_h, scale_step_v, bypass, cfg_busy, frame_start_o, err_o,
                     in_w_o, in_h_o);
          end
          @(negedge clk);
          rst = 1'b0;
        end
        for (int g = 0; g < gap; g++) begin
          de_i = 1'b0;
          cyc();
        end
      end
      hs_i = 1'b1; de_i = 1'b0; err_clr = (ln == f_clr_line);
      cyc();
      if (m_active) begin
        if (err_clr) m_err = 1'b0;
        if (ln == 1) m_ref = npix;
        else if (npix != m_ref) m_err = 1'b1;
      end
      err_clr = 1'b0;
      n_chk++;
      if (err_o !== m_err) begin
        n_fail++;
        $display("FAIL width_check line %0d: err_o=%0b, want %0b", ln, err_o, m_err);
      end
    end
    // Frame end
    hs_i = 1'b1; vs_i = 1'b0; de_i = 1'($urandom);
    cyc();
    if (m_active) begin
      m_in_w = 16'(m_ref); m_in_h = 16'(f_h); m_active = 1'b0;
    end
    n_chk++;
    if (in_w_o !== m_in_w || in_h_o !== m_in_h) begin
      n_fail++;
      $display("FAIL geometry: in_w=%0d in_h=%0d, want %0d %0d", in_w_o, in_h_o, m_in_w, m_in_h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; cfg_step_h = 16'd0; cfg_step_v = 16'd0; cfg_bypass = 1'b0;
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1; err_clr = 1'b0;
    model_reset();
    repeat (3) cyc();
    n_chk++;
    if (scale_step_h !== 16'd128 || scale_step_v !== 16'd128 || bypass !== 1'b0 ||
        err_o !== 1'b0 || in_w_o !== 16'd0 || in_h_o !== 16'd0 || cfg_busy !== 1'b0 ||
        frame_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: h=%0d v=%0d byp=%0b err=%0b w=%0d hgt=%0d busy=%0b fs=%0b",
               scale_step_h, scale_step_v, bypass, err_o, in_w_o, in_h_o, cfg_busy,
               frame_start_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (frame_start_o !== 1'b0) begin
        n_fail++;
        $display("FAIL release_no_fs cycle %0d: frame_start_o=%0b, want 0", i, frame_start_o);
      end
    end
  endtask

  task automatic test_deferred_commit();
    new_frame(8, 6, 0);
    wr_h = 16'd179; wr_v = 16'($urandom_range(1, 400)); wr_b = 1'($urandom);
    f_wr_line = 3;
    run_frame();
    new_frame(8, 6, 0);
    run_frame();
  endtask

  task automatic test_coincident_write();
    new_frame(6, 4, 0);
    wr_h = 16'd64; wr_v = 16'($urandom_range(1, 400)); wr_b = 1'b0;
    f_wr_at_vs = 1'b1;
    run_frame();
    new_frame(6, 4, 0);
    wr_h = 16'd0; wr_v = 16'd0; wr_b = 1'b1;
    f_wr_line = 2;
    run_frame();
    new_frame(6, 4, 0);
    run_frame();
  endtask

  task automatic test_geometry();
    for (int k = 0; k < 2; k++) begin
      new_frame(24, 24, 0);
      run_frame();
    end
    for (int k = 0; k < 2; k++) begin
      new_frame(24, 24, 4);
      run_frame();
    end
  endtask

  task automatic test_width_error();
    new_frame(24, 24, 0);
    f_short_line = 5; f_short_w = 23;
    run_frame();
    new_frame(24, 24, 0);
    run_frame();
    new_frame(24, 8, 0);
    f_clr_line = 2;
    run_frame();
    new_frame(24, 8, 0);
    f_short_line = 5; f_short_w = 23; f_clr_line = 5;
    run_frame();
  endtask

  task automatic test_reset_midframe();
    new_frame(24, 24, 0);
    wr_h = 16'd200; wr_v = 16'd90; wr_b = 1'b1;
    f_wr_line = 3; f_rst_line = 10;
    run_frame();
    new_frame(24, 24, 0);
    run_frame();
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 4; k++) begin
      new_frame(int'($urandom_range(3, 20)), int'($urandom_range(2, 12)),
                int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        f_short_line = int'($urandom_range(2, f_h));
        f_short_w = f_w - int'($urandom_range(1, 2));
      end
      if ($urandom_range(0, 1) == 1) f_clr_line = int'($urandom_range(1, f_h));
      wr_h = 16'($urandom_range(0, 300)); wr_v = 16'($urandom_range(0, 300));
      wr_b = 1'($urandom);
      if ($urandom_range(0, 1) == 1) f_wr_line = int'($urandom_range(1, f_h));
      else f_wr_at_vs = 1'b1;
      run_frame();
    end
    new_frame(5, 3, 0);
    run_frame();
  endtask

  initial begin
    test_reset();
    test_deferred_commit();
    test_coincident_write();
    test_geometry();
    test_width_error();
    test_reset_midframe();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
